change_dispenser: RTL and testbench

Pay-out side of the coin vending machine: takes a change amount owed to the customer and releases coins one at a time through a coin hopper handshake. It uses the largest available coin first and tracks an on-chip inventory of 5- and 10-value coins. It reports completion, any shortfall and the residual amount owed. It sits behind the coin-acceptor/vend FSM, which issues one change request per transaction.

---
 rtl/change_dispenser_if.sv | 39 +++
 rtl/change_dispenser.sv | 144 ++++++++++++++
 tb/tb_change_dispenser.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/change_dispenser_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | change_dispenser_if                                                      |
// | Request, inventory and coin-hopper signals of the change dispenser.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface change_dispenser_if #(
    parameter int AMT_W = 5,
    parameter int CNT_W = 6
);
    logic             req_valid;
    logic             req_ready;
    logic [AMT_W-1:0] req_amount;
    logic             inv_load;
    logic [CNT_W-1:0] inv_n5;
    logic [CNT_W-1:0] inv_n10;
    logic             coin_fire;
    logic             coin_sel;
    logic             hopper_ack;
    logic             done;
    logic             short;
    logic [AMT_W-1:0] remain;
    logic             fault;
    logic [CNT_W-1:0] cnt5;
    logic [CNT_W-1:0] cnt10;

    modport master (
        output req_valid, req_amount, inv_load, inv_n5, inv_n10, hopper_ack,
        input  req_ready, coin_fire, coin_sel, done, short, remain, fault,
               cnt5, cnt10
    );

    modport slave (
        input  req_valid, req_amount, inv_load, inv_n5, inv_n10, hopper_ack,
        output req_ready, coin_fire, coin_sel, done, short, remain, fault,
               cnt5, cnt10
    );
endinterface
`default_nettype wire

// File: rtl/change_dispenser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | change_dispenser                                                         |
// | Greedy 10/5 coin pay-out with inventory tracking and hopper handshake.   |
// | Optional hopper-ack timeout abort: define DISPENSE_TIMEOUT_EN.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module change_dispenser #(
    parameter int AMT_W   = 5,
    parameter int CNT_W   = 6,
    parameter int TIMEOUT = 15
) (
    input  wire logic         clk,
    input  wire logic         rst,
    change_dispenser_if.slave bus
);
    localparam logic [2:0] c_idle     = 3'd0;
    localparam logic [2:0] c_select   = 3'd1;
    localparam logic [2:0] c_fire     = 3'd2;
    localparam logic [2:0] c_wait_ack = 3'd3;
    localparam logic [2:0] c_finish   = 3'd4;

    localparam logic [AMT_W-1:0] c_amt_one = AMT_W'(1);
    localparam logic [AMT_W-1:0] c_amt_two = AMT_W'(2);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    logic [2:0]       r_state;
    logic [AMT_W-1:0] r_rem;
    logic [CNT_W-1:0] r_cnt5;
    logic [CNT_W-1:0] r_cnt10;
    logic             r_coin_sel;
    logic             r_short;
    logic             w_take10;
    logic             w_take5;
    logic             w_expired;

    // Largest coin first; a lone 5-unit residue cannot be paid with a 10-coin.
    assign w_take10 = (r_rem >= c_amt_two) && (r_cnt10 != '0);
    assign w_take5  = (r_rem != '0) && (r_cnt5 != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_idle;
            r_rem      <= '0;
            r_cnt5     <= '0;
            r_cnt10    <= '0;
            r_coin_sel <= 1'b0;
            r_short    <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (bus.inv_load) begin
                        r_cnt5  <= bus.inv_n5;
                        r_cnt10 <= bus.inv_n10;
                    end
                    if (bus.req_valid) begin
                        r_rem   <= bus.req_amount;
                        r_state <= c_select;
                    end
                end
                c_select: begin
                    if (w_take10) begin
                        r_coin_sel <= 1'b1;
                        r_state    <= c_fire;
                    end else if (w_take5) begin
                        r_coin_sel <= 1'b0;
                        r_state    <= c_fire;
                    end else begin
                        r_short <= (r_rem != '0);
                        r_state <= c_finish;
                    end
                end
                c_fire: begin
                    r_state <= c_wait_ack;
                end
                c_wait_ack: begin
                    if (bus.hopper_ack) begin
                        r_rem <= r_rem - (r_coin_sel ? c_amt_two : c_amt_one);
                        if (r_coin_sel) begin
                            r_cnt10 <= r_cnt10 - c_cnt_one;
                        end else begin
                            r_cnt5 <= r_cnt5 - c_cnt_one;
                        end
                        r_state <= c_select;
                    end else if (w_expired) begin
                        // The unconfirmed coin stays owed and stays in stock.
                        r_short <= 1'b1;
                        r_state <= c_finish;
                    end
                end
                c_finish: begin
                    r_short <= 1'b0;
                    r_state <= c_idle;
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

`ifdef DISPENSE_TIMEOUT_EN
    localparam int c_tmo_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT - 1);
    localparam logic [c_tmo_w-1:0] c_tmo_one  = c_tmo_w'(1);

    logic [c_tmo_w-1:0] r_wait_cnt;
    logic               r_fault;

    // Counter value k means WAIT_ACK cycle k+1; an ack on the last one still wins.
    assign w_expired = (r_wait_cnt == c_tmo_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= '0;
            r_fault    <= 1'b0;
        end else begin
            if ((r_state == c_wait_ack) && !bus.hopper_ack && !w_expired) begin
                r_wait_cnt <= r_wait_cnt + c_tmo_one;
            end else begin
                r_wait_cnt <= '0;
            end
            r_fault <= (r_state == c_wait_ack) && !bus.hopper_ack && w_expired;
        end
    end

    assign bus.fault = r_fault;
`else
    assign w_expired = 1'b0;
    // Tied low; TIMEOUT is a non-negative cycle count so this is always 0.
    assign bus.fault = (TIMEOUT < 0);
`endif

    assign bus.req_ready = (r_state == c_idle);
    assign bus.coin_fire = (r_state == c_fire);
    assign bus.coin_sel  = r_coin_sel;
    assign bus.done      = (r_state == c_finish);
    assign bus.short     = r_short;
    assign bus.remain    = (r_state == c_finish) ? r_rem : '0;
    assign bus.cnt5      = r_cnt5;
    assign bus.cnt10     = r_cnt10;

endmodule
`default_nettype wire

// File: tb/tb_change_dispenser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_change_dispenser                                                      |
// | Scoreboard bench: greedy pay-out model, hopper responder, monitor.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_change_dispenser;
    localparam int AMT_W   = 5;
    localparam int CNT_W   = 6;
    localparam int TIMEOUT = 15;

    typedef struct {
        int cycle;
        int short_f;
        int remain;
        int fault;
        int c5;
        int c10;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   m5 = 0;
    int   m10 = 0;

    exp_t exp_q[$];
    int   coin_q[$];
    int   delay_q[$];

    change_dispenser_if #(.AMT_W(AMT_W), .CNT_W(CNT_W)) bus ();

    change_dispenser #(
        .AMT_W   (AMT_W),
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Hopper delay per coin: >=0 acks that many cycles late, -1 never acks.
    function automatic int pick(input int mode);
        int r;
        if (mode != -2) return mode;
        r = int'($urandom_range(0, 9));
`ifdef DISPENSE_TIMEOUT_EN
        if (r == 0) return -1;
        if (r == 1) return TIMEOUT - 1;
`else
        if (r == 0) return 20;
`endif
        return int'($urandom_range(0, 4));
    endfunction

    task automatic issue(input int amt, input bit ld, input int n5, input int n10, input int mode);
        int   n;
        int   k10;
        int   k5;
        int   rem;
        int   acc;
        int   d;
        exp_t e;
        n = 0;
        while (!bus.req_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_wait", int'(bus.req_ready), 1);
        if (ld) begin
            m5  = n5;
            m10 = n10;
        end
        k10 = (amt / 2 < m10) ? amt / 2 : m10;
        k5  = (amt - 2 * k10 < m5) ? amt - 2 * k10 : m5;
        rem = amt;
        acc = cyc + 2;
        e.fault = 0;
        for (int k = 0; k < k10 + k5; k++) begin
            coin_q.push_back((k < k10) ? 1 : 0);
            d = pick(mode);
            delay_q.push_back(d);
            if (d < 0) begin
                acc += TIMEOUT + 1;
                e.fault = 1;
                break;
            end
            acc += 3 + d;
            if (k < k10) begin
                rem -= 2;
                m10--;
            end else begin
                rem -= 1;
                m5--;
            end
        end
        e.cycle   = acc;
        e.short_f = (e.fault != 0 || rem != 0) ? 1 : 0;
        e.remain  = rem;
        e.c5      = m5;
        e.c10     = m10;
        exp_q.push_back(e);
        bus.req_valid  = 1'b1;
        bus.req_amount = AMT_W'(amt);
        bus.inv_load   = ld;
        bus.inv_n5     = CNT_W'(n5);
        bus.inv_n10    = CNT_W'(n10);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.inv_load  = ($urandom_range(0, 2) == 0);
        bus.inv_n5    = CNT_W'($urandom_range(0, 63));
        bus.inv_n10   = CNT_W'($urandom_range(0, 63));
        @(negedge clk);
        bus.inv_load = 1'b0;
    endtask

    // Hopper responder
    initial begin
        int d;
        bus.hopper_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.coin_fire && !rst) begin
                d = (delay_q.size() != 0) ? delay_q.pop_front() : -1;
                if (d >= 0) begin
                    repeat (d + 1) @(negedge clk);
                    bus.hopper_ack = 1'b1;
                    @(negedge clk);
                    bus.hopper_ack = 1'b0;
                end
            end
        end
    end

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.coin_fire) begin
                    if (coin_q.size() == 0) check("unexpected_coin_fire", 1, 0);
                    else check("coin_sel", int'(bus.coin_sel), coin_q.pop_front());
                end
                if (bus.done) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("done_cycle", cyc, e.cycle);
                        check("short", int'(bus.short), e.short_f);
                        check("remain", int'(bus.remain), e.remain);
                        check("fault", int'(bus.fault), e.fault);
                        check("cnt5", int'(bus.cnt5), e.c5);
                        check("cnt10", int'(bus.cnt10), e.c10);
                    end
                end
            end
        end
    end

    initial begin
        @(posedge clk);
        while (cyc < 60000) @(posedge clk);
        $display("FAIL watchdog: got cycle %0d expected finish before 60000", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.req_valid  = 1'b0;
        bus.req_amount = '0;
        bus.inv_load   = 1'b0;
        bus.inv_n5     = '0;
        bus.inv_n10    = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready", int'(bus.req_ready), 1);
        check("rst_coin_fire", int'(bus.coin_fire), 0);
        check("rst_coin_sel", int'(bus.coin_sel), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_short", int'(bus.short), 0);
        check("rst_remain", int'(bus.remain), 0);
        check("rst_fault", int'(bus.fault), 0);
        check("rst_cnt5", int'(bus.cnt5), 0);
        check("rst_cnt10", int'(bus.cnt10), 0);

        issue(3, 1'b1, 4, 4, 0);
        issue(5, 1'b1, 0, 2, 0);
        issue(0, 1'b0, 0, 0, 0);
        issue(2, 1'b1, 0, 1, 4);
        issue(1, 1'b1, 0, 3, 0);
`ifdef DISPENSE_TIMEOUT_EN
        issue(2, 1'b1, 0, 3, -1);
        issue(2, 1'b1, 0, 3, TIMEOUT - 1);
`endif

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0)
                issue(int'($urandom_range(0, 14)), 1'b1, int'($urandom_range(0, 6)),
                      int'($urandom_range(0, 6)), -2);
            else
                issue(int'($urandom_range(0, 14)), 1'b0, 0, 0, -2);
        end

        // Reset while waiting on the hopper: no done, inventory cleared.
        issue(2, 1'b1, 0, 1, 8);
        n = 0;
        while (!bus.coin_fire && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("reset_test_coin_fire", int'(bus.coin_fire), 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        coin_q.delete();
        delay_q.delete();
        m5  = 0;
        m10 = 0;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_req_ready", int'(bus.req_ready), 1);
        check("midrst_cnt5", int'(bus.cnt5), 0);
        check("midrst_cnt10", int'(bus.cnt10), 0);
        repeat (12) @(negedge clk);
        check("stray_ack_req_ready", int'(bus.req_ready), 1);
        check("stray_ack_cnt5", int'(bus.cnt5), 0);
        check("stray_ack_cnt10", int'(bus.cnt10), 0);
        issue(3, 1'b1, 2, 1, 1);

        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
